rs232_transmitter: RTL and testbench

RS232_TRANSMITTER -- requirements
Module: rs232_transmitter

---
 rtl/rs232_pkg.sv | 16 +
 rtl/rs232_tx_fifo.sv | 67 ++++++
 rtl/rs232_transmitter.sv | 140 ++++++++++++++
 tb/tb_rs232_transmitter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs232_pkg.sv
// Shared definitions for the RS-232 transmit and receive paths: line timing default
// and the transmit FSM state encoding.
package rs232_pkg;

    // 9600 baud from a 30 MHz clock; the receiver derives its bit timing from the same value.
    localparam int unsigned CLK_DIVIDER_DEFAULT = 3125;
    localparam int unsigned TICK_W              = 16;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StStart = 3'd1,
        StData  = 3'd2,
        StStop  = 3'd3
    } tx_state_e;

endpackage

// File: rtl/rs232_tx_fifo.sv
// Byte FIFO feeding the transmitter; head byte is visible on dout while not empty.
// Pushes while full and pops while empty are ignored.
module rs232_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push,
    input  logic [7:0]     din,
    input  logic           pop,
    output logic [7:0]     dout,
    output logic           full,
    output logic           empty,
    output logic [PTR_W:0] count
);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // Simultaneous push and pop leave the occupancy unchanged.
        if (do_push && !do_pop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/rs232_transmitter.sv
// Buffered RS-232 transmitter: 8N1 frames, LSB first, CLK_DIVIDER clocks per bit,
// queued bytes sent back-to-back with no idle gap between frames.
module rs232_transmitter
    import rs232_pkg::*;
#(
    parameter int unsigned CLK_DIVIDER = CLK_DIVIDER_DEFAULT,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       data_valid,
    output logic       ready,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [TICK_W-1:0] TickLast = TICK_W'(CLK_DIVIDER - 1);

    tx_state_e         state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              frame_done_q, frame_done_d;

    logic              fifo_pop;
    logic [7:0]        fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              tick_last;

    rs232_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (data_valid),
        .din   (data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign ready      = (fifo_count != CNT_W'(FIFO_DEPTH));
    assign busy       = (state_q != StIdle) || (fifo_count != '0);
    assign tx         = tx_q;
    assign frame_done = frame_done_q;
    assign tick_last  = (tick_q == TickLast);

    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q + TICK_W'(1);
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        tx_d         = tx_q;
        frame_done_d = 1'b0;
        fifo_pop     = 1'b0;

        case (state_q)
            StIdle: begin
                tick_d = '0;
                tx_d   = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    tx_d     = 1'b0;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (tick_last) begin
                    tick_d    = '0;
                    tx_d      = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = '0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (tick_last) begin
                    tick_d = '0;
                    if (bit_cnt_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = StStop;
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            StStop: begin
                if (tick_last) begin
                    tick_d       = '0;
                    frame_done_d = 1'b1;
                    // Chain straight into the next start bit when more data is queued.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        tx_d     = 1'b0;
                        state_d  = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d   = StIdle;
                tick_d    = '0;
                bit_cnt_d = '0;
                tx_d      = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            tick_q       <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            tx_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_rs232_transmitter.sv
// Self-checking bench: a frame-schedule model predicts tx/busy/ready/frame_done every cycle.
module tb_rs232_transmitter;

    localparam int DIV   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * DIV;
    localparam int SDIV  = 3125;

    logic       clk = 1'b0;
    logic       rst, data_valid, ready, tx, busy, frame_done;
    logic [7:0] data;
    logic       rst_s, dv_s, ready_s, tx_s, busy_s, fd_s;
    logic [7:0] data_s;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    // Model: each accepted byte becomes a frame starting at
    // max(push edge + 1, previous frame start + FRAME).
    int         push_edge_q[$];
    int         start_q[$];
    logic [7:0] byte_q[$];
    int         last_start = -1000;
    logic       tx_hist[$];
    logic       fd_hist[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rs232_transmitter #(
        .CLK_DIVIDER (DIV),
        .FIFO_DEPTH  (DEPTH)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .data_valid (data_valid),
        .ready      (ready),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    rs232_transmitter #(
        .CLK_DIVIDER (SDIV),
        .FIFO_DEPTH  (DEPTH)
    ) u_dut_slow (
        .clk        (clk),
        .rst        (rst_s),
        .data       (data_s),
        .data_valid (dv_s),
        .ready      (ready_s),
        .tx         (tx_s),
        .busy       (busy_s),
        .frame_done (fd_s)
    );

    function automatic int model_count(input int k);
        int n = 0;
        foreach (push_edge_q[i]) if (push_edge_q[i] <= k) n++;
        foreach (start_q[i]) if (start_q[i] <= k) n--;
        return n;
    endfunction

    function automatic logic model_in_frame(input int k);
        foreach (start_q[i]) if (k >= start_q[i] && k < start_q[i] + FRAME) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic model_tx(input int k);
        int         idx;
        logic [7:0] b;
        foreach (start_q[i]) begin
            if (k >= start_q[i] && k < start_q[i] + FRAME) begin
                idx = (k - start_q[i]) / DIV;
                b   = byte_q[i];
                if (idx == 0) return 1'b0;
                if (idx == 9) return 1'b1;
                return b[idx-1];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic model_fd(input int k);
        foreach (start_q[i]) if (k == start_q[i] + FRAME) return 1'b1;
        return 1'b0;
    endfunction

    // Drive one cycle of inputs, advance to the following negedge and check all outputs.
    task automatic step(input logic dv, input logic [7:0] d, input logic r, output logic acc);
        int   k, s;
        logic e_tx, e_fd, e_busy, e_ready;
        k          = cyc;
        acc        = 1'b0;
        data_valid = dv;
        data       = d;
        rst        = r;
        if (r) begin
            push_edge_q.delete();
            start_q.delete();
            byte_q.delete();
            last_start = -1000;
        end else if (dv && model_count(k) < DEPTH) begin
            acc = 1'b1;
            s   = (k + 2 > last_start + FRAME) ? k + 2 : last_start + FRAME;
            push_edge_q.push_back(k + 1);
            start_q.push_back(s);
            byte_q.push_back(d);
            last_start = s;
        end
        @(posedge clk);
        @(negedge clk);
        k       = cyc;
        e_tx    = model_tx(k);
        e_fd    = model_fd(k);
        e_busy  = model_in_frame(k) || (model_count(k) != 0);
        e_ready = (model_count(k) != DEPTH);
        n_checks += 4;
        if (tx !== e_tx) begin
            n_errors++;
            $display("FAIL tx @%0d: got %b, expected %b", k, tx, e_tx);
        end
        if (frame_done !== e_fd) begin
            n_errors++;
            $display("FAIL frame_done @%0d: got %b, expected %b", k, frame_done, e_fd);
        end
        if (busy !== e_busy) begin
            n_errors++;
            $display("FAIL busy @%0d: got %b, expected %b", k, busy, e_busy);
        end
        if (ready !== e_ready) begin
            n_errors++;
            $display("FAIL ready @%0d: got %b, expected %b", k, ready, e_ready);
        end
        tx_hist.push_back(tx);
        fd_hist.push_back(frame_done);
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, a);
    endtask

    task automatic clear_hist();
        tx_hist.delete();
        fd_hist.delete();
    endtask

    function automatic int first_low();
        foreach (tx_hist[i]) if (tx_hist[i] === 1'b0) return i;
        return -1;
    endfunction

    function automatic int fd_total();
        int n = 0;
        foreach (fd_hist[i]) if (fd_hist[i] === 1'b1) n++;
        return n;
    endfunction

    function automatic int last_fd();
        int p = -1;
        foreach (fd_hist[i]) if (fd_hist[i] === 1'b1) p = i;
        return p;
    endfunction

    task automatic test_reset();
        logic a;
        rst_s = 1'b1; dv_s = 1'b0; data_s = 8'h00;
        step(1'b1, 8'h5A, 1'b1, a);
        step(1'b0, 8'h00, 1'b1, a);
        rst_s = 1'b0;
        n_checks += 3;
        if (tx !== 1'b1) begin n_errors++; $display("FAIL reset_tx: got %b, expected 1", tx); end
        if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        if (ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b, expected 1", ready); end
    endtask

    task automatic test_single();
        logic a;
        int   lo, fd;
        clear_hist();
        step(1'b1, 8'hA5, 1'b0, a);
        idle(55);
        lo = first_low();
        fd = last_fd();
        n_checks += 3;
        if (lo != 1) begin n_errors++; $display("FAIL single_latency: got %0d, expected 1", lo); end
        if (fd_total() != 1) begin
            n_errors++; $display("FAIL single_fd_count: got %0d, expected 1", fd_total());
        end
        if (fd - lo != FRAME) begin
            n_errors++; $display("FAIL single_fd_time: got %0d, expected %0d", fd - lo, FRAME);
        end
    endtask

    task automatic test_back_to_back();
        logic a;
        int   idx = 0, lo, fd;
        clear_hist();
        for (int i = 0; i < 300; i++) begin
            if (idx < 6) begin
                step(1'b1, 8'(idx + 1), 1'b0, a);
                if (a) idx++;
            end else begin
                step(1'b0, 8'h00, 1'b0, a);
            end
        end
        lo = first_low();
        fd = last_fd();
        n_checks += 2;
        if (fd_total() != 6) begin
            n_errors++; $display("FAIL b2b_fd_count: got %0d, expected 6", fd_total());
        end
        if (fd - lo != 6 * FRAME) begin
            n_errors++; $display("FAIL b2b_span: got %0d, expected %0d", fd - lo, 6 * FRAME);
        end
    endtask

    task automatic test_full_drop();
        logic a;
        clear_hist();
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, a);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h77, 1'b0, a);
            n_checks++;
            if (ready !== 1'b0) begin
                n_errors++; $display("FAIL full_ready: got %b, expected 0", ready);
            end
        end
        idle(260);
        n_checks++;
        if (fd_total() != 5) begin
            n_errors++; $display("FAIL full_fd_count: got %0d, expected 5", fd_total());
        end
    endtask

    task automatic test_reset_mid_frame();
        logic a;
        int   s0;
        step(1'b1, 8'h3C, 1'b0, a);
        s0 = start_q[start_q.size() - 1];
        step(1'b1, 8'h11, 1'b0, a);
        step(1'b1, 8'h22, 1'b0, a);
        while (cyc < s0 + 4 * DIV + 1) step(1'b0, 8'h00, 1'b0, a);
        clear_hist();
        step(1'b0, 8'h00, 1'b1, a);
        n_checks += 4;
        if (tx !== 1'b1) begin n_errors++; $display("FAIL abort_tx: got %b, expected 1", tx); end
        if (busy !== 1'b0) begin n_errors++; $display("FAIL abort_busy: got %b, expected 0", busy); end
        if (ready !== 1'b1) begin n_errors++; $display("FAIL abort_ready: got %b, expected 1", ready); end
        if (frame_done !== 1'b0) begin
            n_errors++; $display("FAIL abort_fd: got %b, expected 0", frame_done);
        end
        idle(100);
        n_checks += 2;
        if (fd_total() != 0) begin
            n_errors++; $display("FAIL abort_fd_count: got %0d, expected 0", fd_total());
        end
        if (first_low() != -1) begin
            n_errors++; $display("FAIL abort_tx_low: got index %0d, expected none", first_low());
        end
    endtask

    task automatic test_zero_ff();
        logic a, v;
        int   pos, len;
        int   exp_len [3] = '{36, 4, 4};
        clear_hist();
        step(1'b1, 8'h00, 1'b0, a);
        step(1'b1, 8'hFF, 1'b0, a);
        idle(120);
        pos = first_low();
        n_checks++;
        if (pos < 0) begin
            n_errors++; $display("FAIL zero_ff_start: got none, expected a low bit");
        end else begin
            for (int r = 0; r < 4; r++) begin
                v   = tx_hist[pos];
                len = 0;
                while (pos < tx_hist.size() && tx_hist[pos] === v) begin
                    len++;
                    pos++;
                end
                n_checks++;
                if (r < 3 && len != exp_len[r]) begin
                    n_errors++;
                    $display("FAIL zero_ff_run%0d: got %0d, expected %0d", r, len, exp_len[r]);
                end else if (r == 3 && (len < 36 || v !== 1'b1)) begin
                    n_errors++;
                    $display("FAIL zero_ff_run3: got %0d of %b, expected >=36 of 1", len, v);
                end
            end
        end
    endtask

    task automatic test_random();
        logic a, dv, r;
        clear_hist();
        for (int i = 0; i < 400; i++) begin
            dv = ($urandom_range(0, 2) == 0);
            r  = ($urandom_range(0, 149) == 0);
            step(dv, 8'($urandom_range(0, 255)), r, a);
        end
        idle(260);
    endtask

    task automatic test_slow();
        logic [7:0] b = 8'h55;
        logic       e;
        int         idx, fd_n = 0, fd_at = -1;
        dv_s   = 1'b1;
        data_s = b;
        @(posedge clk);
        @(negedge clk);
        dv_s = 1'b0;
        for (int c = 1; c <= 10 * SDIV + 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (fd_s === 1'b1) begin
                fd_n++;
                if (fd_at < 0) fd_at = c;
            end
            if (c <= 10 * SDIV && ((c - 1) % SDIV == 0 || (c - 1) % SDIV == SDIV - 1)) begin
                idx = (c - 1) / SDIV;
                e   = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : b[idx-1];
                n_checks++;
                if (tx_s !== e) begin
                    n_errors++; $display("FAIL slow_tx @%0d: got %b, expected %b", c, tx_s, e);
                end
            end
        end
        n_checks += 2;
        if (fd_n != 1) begin n_errors++; $display("FAIL slow_fd_count: got %0d, expected 1", fd_n); end
        if (fd_at - 1 != 10 * SDIV) begin
            n_errors++; $display("FAIL slow_fd_time: got %0d, expected %0d", fd_at - 1, 10 * SDIV);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full_drop();
        test_reset_mid_frame();
        test_zero_ff();
        test_random();
        test_slow();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
